// File: rtl/sw_pkg.sv
// Shared types and helpers for the Smith-Waterman job driver.
package sw_pkg;

    // Driver FSM states
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        REPORT
    } drv_state_e;

    // 2-bit nucleotide encoding used on the array data_in port
    typedef enum logic [1:0] {
        _T = 2'b00,
        _C = 2'b01,
        _A = 2'b10,
        _G = 2'b11
    } base_e;

    // Bits needed to represent n itself (8 for 128), so qlen can reach LENGTH
    function automatic int log2b(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((n >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    // Biased zero score of the scoring array
    function automatic int zero_score(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/sw_base_serializer.sv
// Target word shift register: accepts packed words, emits one base per cycle
// and tracks how many target bases are still owed to the array.
module sw_base_serializer
    import sw_pkg::*;
#(
    parameter int WORD_BASES = 16,
    parameter int TLEN_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    active,
    input  logic [TLEN_WIDTH-1:0]   tlen,
    input  logic                    tgt_valid,
    output logic                    tgt_ready,
    input  logic [2*WORD_BASES-1:0] tgt_data,
    output logic [1:0]              base,
    output logic                    base_vld,
    output logic                    base_last
);
    localparam int CW = $clog2(WORD_BASES + 1);

    logic [2*WORD_BASES-1:0] shreg;
    logic [CW-1:0]           word_cnt;
    logic [TLEN_WIDTH-1:0]   remain;
    logic                    empty;
    logic                    take;

    // An empty register forwards base 0 of the incoming word directly, so a
    // word accepted while empty costs no bubble; a word is only requested
    // while more bases are owed than the register still holds.
    always_comb begin
        empty     = (word_cnt == '0);
        tgt_ready = active && (empty || word_cnt == CW'(1)) &&
                    (remain > TLEN_WIDTH'(word_cnt));
        take      = tgt_ready && tgt_valid;
        base_vld  = active && (!empty || take);
        base      = empty ? tgt_data[1:0] : shreg[1:0];
        base_last = base_vld && (remain == TLEN_WIDTH'(1));
    end

    // Shift/load the word register and count down the owed bases
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            word_cnt <= '0;
            remain   <= '0;
        end else if (start) begin
            word_cnt <= '0;
            remain   <= tlen;
        end else if (active) begin
            if (take && empty) begin
                shreg    <= tgt_data >> 2;
                word_cnt <= CW'(WORD_BASES - 1);
            end else if (take) begin
                shreg    <= tgt_data;
                word_cnt <= CW'(WORD_BASES);
            end else if (!empty) begin
                shreg    <= shreg >> 2;
                word_cnt <= word_cnt - CW'(1);
            end
            if (base_vld) remain <= remain - TLEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sw_job_driver.sv
// Host-side job driver for the Smith-Waterman scoring array: clears the
// array, streams the target one base per cycle and returns the score.
// Optional macro SW_DRIVER_TIMEOUT_EN adds a DRAIN timeout counter.
module sw_job_driver
    import sw_pkg::*;
#(
    parameter int                     SCORE_WIDTH = 12,
    parameter int                     LENGTH      = 128,
    parameter int                     LOG_LENGTH  = log2b(LENGTH),
    parameter int                     WORD_BASES  = 16,
    parameter int                     TLEN_WIDTH  = 16,
    parameter int                     TIMEOUT     = LENGTH + 8,
    parameter logic [SCORE_WIDTH-1:0] ZERO        = SCORE_WIDTH'(zero_score(SCORE_WIDTH))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2*LENGTH-1:0]     cmd_query,
    input  logic [LOG_LENGTH-1:0]   cmd_qlen,
    input  logic [TLEN_WIDTH-1:0]   cmd_tlen,
    input  logic                    tgt_valid,
    output logic                    tgt_ready,
    input  logic [2*WORD_BASES-1:0] tgt_data,
    output logic                    sc_rst_n,
    output logic                    sc_en,
    output logic [1:0]              sc_data,
    output logic [2*LENGTH-1:0]     sc_query,
    output logic [LOG_LENGTH-1:0]   sc_output_select,
    input  logic [SCORE_WIDTH-1:0]  sc_result,
    input  logic                    sc_vld,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [SCORE_WIDTH-1:0]  res_score,
    output logic                    res_timeout
);
    drv_state_e state, state_nxt;
    logic       accept, active, clr_cnt, empty_job;
    logic       base_vld, base_last;
    logic [1:0] base, last_base;

`ifdef SW_DRIVER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] drain_cnt;
    logic          timeout_q;
    logic          drain_expired;
    assign drain_expired = (drain_cnt == TW'(TIMEOUT - 1));
`endif

    assign accept = cmd_ready && cmd_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and state-decoded outputs; rst masks the handshake/reset
    // outputs so they show their reset values in the very cycle rst is high
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        active    = 1'b0;
        sc_rst_n  = !rst;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) state_nxt = CLEAR;
            end
            CLEAR: begin
                sc_rst_n = 1'b0;
                if (clr_cnt) state_nxt = empty_job ? REPORT : STREAM;
            end
            STREAM: begin
                active = !rst;
                if (base_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (sc_vld) state_nxt = REPORT;
`ifdef SW_DRIVER_TIMEOUT_EN
                else if (drain_expired) state_nxt = REPORT;
`endif
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    sw_base_serializer #(
        .WORD_BASES (WORD_BASES),
        .TLEN_WIDTH (TLEN_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .active    (active),
        .tlen      (cmd_tlen),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .base      (base),
        .base_vld  (base_vld),
        .base_last (base_last)
    );

    // Bubbles keep the previous base on data_in; only en drops
    assign sc_en   = base_vld;
    assign sc_data = base_vld ? base : last_base;

    // Job latch, CLEAR length, last-sent base and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_query         <= '0;
            sc_output_select <= '0;
            res_score        <= ZERO;
            clr_cnt          <= 1'b0;
            empty_job        <= 1'b0;
            last_base        <= _T;
        end else begin
            if (accept) begin
                sc_query         <= cmd_query;
                sc_output_select <= cmd_qlen;
                res_score        <= ZERO;
                clr_cnt          <= 1'b0;
                empty_job        <= (cmd_qlen == '0) || (cmd_tlen == '0);
            end
            if (state == CLEAR)           clr_cnt   <= 1'b1;
            if (state == DRAIN && sc_vld) res_score <= sc_result;
            if (base_vld)                 last_base <= base;
        end
    end

`ifdef SW_DRIVER_TIMEOUT_EN
    // Count DRAIN cycles; a job that never sees sc_vld reports a timeout
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            drain_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + TW'(1);
            if (drain_expired && !sc_vld) timeout_q <= 1'b1;
        end
    end
    assign res_timeout = timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sw_job_driver.sv
// Self-checking bench for sw_job_driver: random jobs against a queue-based
// model of the target stream, stub array answering sc_vld in DRAIN.
module tb_sw_job_driver;

    localparam logic [11:0] ZERO_SC = 12'h800;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [255:0] cmd_query = '0;
    logic [7:0]   cmd_qlen = '0;
    logic [15:0]  cmd_tlen = '0;
    logic         tgt_valid = 1'b0;
    logic         tgt_ready;
    logic [31:0]  tgt_data = '0;
    logic         sc_rst_n, sc_en;
    logic [1:0]   sc_data;
    logic [255:0] sc_query;
    logic [7:0]   sc_output_select;
    logic [11:0]  sc_result = '0;
    logic         sc_vld = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [11:0]  res_score;
    logic         res_timeout;

    int n_checks = 0;
    int n_err    = 0;

    // Observations of the most recent job
    int           acc_cyc, first_en, last_en, en_count, words_taken, bubbles;
    int           first_rv, rv_n, stable_err, hold_err, rdy_rep;
    int           clr_n, clr_first, order_err;
    bit           timed_out;
    logic [11:0]  rv_score;
    logic         rv_tmo;
    logic [255:0] g_query;

    always #5 clk = ~clk;

    sw_job_driver dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_query        (cmd_query),
        .cmd_qlen         (cmd_qlen),
        .cmd_tlen         (cmd_tlen),
        .tgt_valid        (tgt_valid),
        .tgt_ready        (tgt_ready),
        .tgt_data         (tgt_data),
        .sc_rst_n         (sc_rst_n),
        .sc_en            (sc_en),
        .sc_data          (sc_data),
        .sc_query         (sc_query),
        .sc_output_select (sc_output_select),
        .sc_result        (sc_result),
        .sc_vld           (sc_vld),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_score        (res_score),
        .res_timeout      (res_timeout)
    );

    // Runs one job. gap_word: withhold that word until 3 empty cycles pass
    // (-1 none). vld_at: DRAIN cycle (1-based) where the stub answers, 0 never.
    // hold: cycles of res_valid before res_ready is raised.
    task automatic run_job(input int qlen, input int tlen, input int gap_word,
                           input int vld_at, input logic [11:0] score, input int hold);
        logic [31:0] words[$];
        logic [1:0]  exp_b[$];
        logic [1:0]  obs_b[$];
        logic [1:0]  last_b;
        int          cyc, drain_n, gaps;
        bit          accepted, done;
        for (int w = 0; w < (tlen + 15) / 16 + 1; w++) words.push_back($urandom);
        for (int i = 0; i < tlen; i++) begin
            logic [31:0] wd;
            wd = words[i / 16];
            exp_b.push_back(wd[2 * (i % 16) +: 2]);
        end
        g_query = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
        acc_cyc = -1; first_en = -1; last_en = -1; en_count = 0; words_taken = 0;
        first_rv = -1; rv_n = 0; stable_err = 0; hold_err = 0; rdy_rep = 0;
        clr_n = 0; clr_first = -1; order_err = 0; timed_out = 0;
        rv_score = '0; rv_tmo = 1'b0;
        accepted = 0; done = 0; gaps = 0; cyc = 0; last_b = 2'b00;
        while (!done) begin
            if (cyc >= 1500) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            cmd_valid = !accepted;
            cmd_query = g_query;
            cmd_qlen  = 8'(qlen);
            cmd_tlen  = 16'(tlen);
            tgt_valid = accepted && (words_taken < words.size()) &&
                        !(words_taken == gap_word && gaps < 3);
            tgt_data  = (words_taken < words.size()) ? words[words_taken] : 32'h0;
            drain_n   = (tlen > 0 && en_count == tlen) ? cyc - last_en : 0;
            if (drain_n > 0) begin
                sc_vld    = (vld_at > 0 && drain_n == vld_at);
                sc_result = sc_vld ? score : 12'h000;
            end else begin
                // noise the array flag outside DRAIN: it must be ignored
                sc_vld    = 1'($urandom_range(0, 1));
                sc_result = 12'hFFF;
            end
            res_ready = (rv_n >= hold);
            #1;
            if (cmd_valid && cmd_ready) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (!sc_rst_n) begin
                clr_n++;
                if (clr_first < 0) clr_first = cyc;
            end
            if (words_taken == gap_word && tgt_ready && !tgt_valid && !sc_en && en_count > 0)
                gaps++;
            if (tgt_valid && tgt_ready) words_taken++;
            if (sc_en) begin
                obs_b.push_back(sc_data);
                last_b = sc_data;
                en_count++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end else if (en_count > 0 && en_count < tlen && sc_data !== last_b) begin
                hold_err++;
            end
            if (res_valid) begin
                if (cmd_ready) rdy_rep++;
                if (rv_n == 0) begin
                    first_rv = cyc;
                    rv_score = res_score;
                    rv_tmo   = res_timeout;
                end else if (res_score !== rv_score || res_timeout !== rv_tmo) begin
                    stable_err++;
                end
                if (res_ready) done = 1;
                rv_n++;
            end
            cyc++;
        end
        bubbles = (en_count > 0) ? last_en - first_en + 1 - en_count : 0;
        if (obs_b.size() != exp_b.size()) order_err = 1;
        else
            for (int i = 0; i < exp_b.size(); i++)
                if (obs_b[i] !== exp_b[i]) order_err++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
        n_checks++; if (tgt_ready !== 1'b0) begin n_err++; $display("FAIL rst_tgt_ready: got %b expected 0", tgt_ready); end
        n_checks++; if (sc_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_sc_rst_n: got %b expected 0", sc_rst_n); end
        n_checks++; if ({sc_en, sc_data} !== 3'b000) begin n_err++; $display("FAIL rst_sc_en_data: got %b expected 000", {sc_en, sc_data}); end
        n_checks++; if (sc_query !== '0 || sc_output_select !== 8'd0) begin n_err++; $display("FAIL rst_query: got sel %0d expected 0 with zero query", sc_output_select); end
        n_checks++; if (res_valid !== 1'b0 || res_timeout !== 1'b0) begin n_err++; $display("FAIL rst_res_flags: got %b%b expected 00", res_valid, res_timeout); end
        n_checks++; if (res_score !== ZERO_SC) begin n_err++; $display("FAIL rst_res_score: got %h expected %h", res_score, ZERO_SC); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_basic_stream();
        run_job(4, 20, -1, 5, 12'h80A, 3);
        n_checks++; if (timed_out) begin n_err++; $display("FAIL basic_done: got timeout expected completion"); end
        n_checks++; if (words_taken !== 2) begin n_err++; $display("FAIL basic_words: got %0d expected 2", words_taken); end
        n_checks++; if (en_count !== 20) begin n_err++; $display("FAIL basic_en_count: got %0d expected 20", en_count); end
        n_checks++; if (first_en !== acc_cyc + 3) begin n_err++; $display("FAIL basic_first_en: got %0d expected %0d", first_en, acc_cyc + 3); end
        n_checks++; if (bubbles !== 0) begin n_err++; $display("FAIL basic_bubbles: got %0d expected 0", bubbles); end
        n_checks++; if (order_err !== 0) begin n_err++; $display("FAIL basic_order: got %0d bad bases expected 0", order_err); end
        n_checks++; if (clr_n !== 2 || clr_first !== acc_cyc + 1) begin n_err++; $display("FAIL basic_clear: got %0d cycles at %0d expected 2 at %0d", clr_n, clr_first, acc_cyc + 1); end
        n_checks++; if (first_rv !== last_en + 6) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", first_rv, last_en + 6); end
        n_checks++; if (rv_score !== 12'h80A || rv_tmo !== 1'b0) begin n_err++; $display("FAIL basic_score: got %h/%b expected 80a/0", rv_score, rv_tmo); end
        n_checks++; if (stable_err !== 0 || rv_n !== 4) begin n_err++; $display("FAIL basic_hold: got %0d changes over %0d cycles expected 0 over 4", stable_err, rv_n); end
        n_checks++; if (sc_query !== g_query || sc_output_select !== 8'd4) begin n_err++; $display("FAIL basic_query: got sel %0d expected 4 with latched query", sc_output_select); end
        n_checks++; if (rdy_rep !== 0) begin n_err++; $display("FAIL basic_ready_in_report: got %0d expected 0", rdy_rep); end
    endtask

    task automatic test_bubbles();
        run_job(16, 40, 1, 2, 12'h123, 0);
        n_checks++; if (bubbles !== 3) begin n_err++; $display("FAIL bubble_count: got %0d expected 3", bubbles); end
        n_checks++; if (en_count !== 40 || words_taken !== 3) begin n_err++; $display("FAIL bubble_len: got %0d bases %0d words expected 40 and 3", en_count, words_taken); end
        n_checks++; if (order_err !== 0 || hold_err !== 0) begin n_err++; $display("FAIL bubble_order: got %0d/%0d bad expected 0/0", order_err, hold_err); end
        n_checks++; if (rv_score !== 12'h123) begin n_err++; $display("FAIL bubble_score: got %h expected 123", rv_score); end
    endtask

    task automatic test_empty_job();
        int ql[2];
        int tl[2];
        ql[0] = 5; tl[0] = 0;
        ql[1] = 0; tl[1] = 10;
        for (int k = 0; k < 2; k++) begin
            run_job(ql[k], tl[k], -1, 0, 12'h000, 1);
            n_checks++; if (en_count !== 0 || words_taken !== 0) begin n_err++; $display("FAIL empty_%0d_stream: got %0d en %0d words expected 0", k, en_count, words_taken); end
            n_checks++; if (first_rv !== acc_cyc + 3) begin n_err++; $display("FAIL empty_%0d_latency: got %0d expected %0d", k, first_rv, acc_cyc + 3); end
            n_checks++; if (rv_score !== ZERO_SC || rv_tmo !== 1'b0) begin n_err++; $display("FAIL empty_%0d_result: got %h/%b expected 800/0", k, rv_score, rv_tmo); end
        end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 5; j++) begin
            int tlen, nw, gap, vat;
            logic [11:0] sc;
            tlen = $urandom_range(1, 70);
            nw   = (tlen + 15) / 16;
            gap  = (nw >= 2) ? int'($urandom_range(1, nw - 1)) : -1;
            vat  = $urandom_range(1, 10);
            sc   = 12'($urandom);
            run_job($urandom_range(1, 128), tlen, gap, vat, sc, $urandom_range(0, 3));
            n_checks++; if (en_count !== tlen || order_err !== 0) begin n_err++; $display("FAIL rand_%0d_stream: got %0d bases %0d bad expected %0d and 0", j, en_count, order_err, tlen); end
            n_checks++; if (words_taken !== nw || bubbles !== (gap > 0 ? 3 : 0)) begin n_err++; $display("FAIL rand_%0d_words: got %0d words %0d bubbles expected %0d and %0d", j, words_taken, bubbles, nw, gap > 0 ? 3 : 0); end
            n_checks++; if (rv_score !== sc || first_rv !== last_en + vat + 1) begin n_err++; $display("FAIL rand_%0d_result: got %h at %0d expected %h at %0d", j, rv_score, first_rv, sc, last_en + vat + 1); end
        end
    endtask

    task automatic test_back_to_back();
        run_job(7, 9, -1, 1, 12'h456, 2);
        run_job(9, 17, 1, 3, 12'h789, 0);
        n_checks++; if (acc_cyc !== 0) begin n_err++; $display("FAIL b2b_accept: got cycle %0d expected 0", acc_cyc); end
        n_checks++; if (rdy_rep !== 0 || rv_score !== 12'h789) begin n_err++; $display("FAIL b2b_result: got %h ready %0d expected 789 ready 0", rv_score, rdy_rep); end
    endtask

    task automatic test_reset_mid_stream();
        int  n_en = 0;
        int  k = 0;
        bit  acc = 0;
        tgt_data = $urandom;
        while (n_en < 10 && k < 100) begin
            @(posedge clk); #1;
            cmd_valid = !acc;
            cmd_qlen  = 8'd8;
            cmd_tlen  = 16'd50;
            tgt_valid = 1'b1;
            sc_vld    = 1'b0;
            res_ready = 1'b0;
            #1;
            if (cmd_valid && cmd_ready) acc = 1;
            if (sc_en) n_en++;
            k++;
        end
        n_checks++; if (n_en !== 10) begin n_err++; $display("FAIL midrst_reach_stream: got %0d en expected 10", n_en); end
        @(posedge clk); #1;
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({sc_en, sc_rst_n, res_valid, tgt_ready} !== 4'b0000) begin n_err++; $display("FAIL midrst_outputs: got %b expected 0000", {sc_en, sc_rst_n, res_valid, tgt_ready}); end
        rst = 1'b0;
        tgt_valid = 1'b0;
        run_job(3, 33, -1, 4, 12'h0F0, 1);
        n_checks++; if (en_count !== 33 || order_err !== 0 || words_taken !== 3) begin n_err++; $display("FAIL midrst_clean_job: got %0d bases %0d bad %0d words expected 33/0/3", en_count, order_err, words_taken); end
        n_checks++; if (rv_score !== 12'h0F0 || first_en !== acc_cyc + 3) begin n_err++; $display("FAIL midrst_clean_result: got %h first_en %0d expected 0f0 at %0d", rv_score, first_en, acc_cyc + 3); end
    endtask

`ifdef SW_DRIVER_TIMEOUT_EN
    task automatic test_timeout();
        run_job(4, 5, -1, 0, 12'h000, 0);
        n_checks++; if (rv_tmo !== 1'b1 || rv_score !== ZERO_SC) begin n_err++; $display("FAIL timeout_result: got %h/%b expected 800/1", rv_score, rv_tmo); end
        n_checks++; if (first_rv !== last_en + 137) begin n_err++; $display("FAIL timeout_latency: got %0d expected %0d", first_rv, last_en + 137); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_stream();
        test_bubbles();
        test_empty_job();
        test_random_jobs();
        test_back_to_back();
        test_reset_mid_stream();
`ifdef SW_DRIVER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sw_job_driver.md
# sw_job_driver

Host-side driver for the Smith-Waterman systolic scoring array. It accepts one alignment job at a time: a packed query, a query length and a target length. It clears the array, serialises the packed target stream into one 2-bit base per cycle on the array's base/enable inputs and waits for the array's valid flag. It then returns the score over a ready/valid result port, so it forms the upstream and downstream counterpart of the scoring module.

## Interface
Parameters:
- SCORE_WIDTH, 12, score width; must match the scoring module.
- LENGTH, 128, PEs in the array, which is the maximum query length.
- LOG_LENGTH, log2b(LENGTH), width of qlen/output_select (8 for 128).
- WORD_BASES, 16, bases per target word; the word width is 2*WORD_BASES.
- TLEN_WIDTH, 16, target length counter width.
- TIMEOUT, LENGTH+8, maximum DRAIN cycles to wait for sc_vld.
- ZERO, 2**(SCORE_WIDTH-1), biased zero score.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in/out  1  job handshake.
- cmd_query  in  2*LENGTH  query bases; base i is at bits [2i+1:2i].
- cmd_qlen  in  LOG_LENGTH  query length, 0..LENGTH.
- cmd_tlen  in  TLEN_WIDTH  target length in bases.
- tgt_valid / tgt_ready  in/out  1  target word handshake.
- tgt_data  in  2*WORD_BASES  packed bases, first base in bits [1:0].
- sc_rst_n  out  1  active-low reset to the scoring module.
- sc_en  out  1  drives the array en_in.
- sc_data  out  2  drives the array data_in.
- sc_query  out  2*LENGTH  registered query.
- sc_output_select  out  LOG_LENGTH  registered qlen.
- sc_result  in  SCORE_WIDTH  array result.
- sc_vld  in  1  array valid.
- res_valid / res_ready  out/in  1  result handshake.
- res_score  out  SCORE_WIDTH  final score.
- res_timeout  out  1  set when DRAIN expired without sc_vld.

## Operation
- FSM states are IDLE, CLEAR, STREAM, DRAIN and REPORT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch query, qlen and tlen, then go to CLEAR.
- CLEAR:
  - Lasts exactly 2 cycles with sc_rst_n=0, sc_en=0.
  - Then goes to STREAM.
  - If tlen==0 or qlen==0, it goes to REPORT instead, with res_score=ZERO and res_timeout=0.
- STREAM:
  - A shift register holds one target word.
  - tgt_ready=1 when the register is empty, or when its last base is sent this cycle. This allows back-to-back words at 1 base/cycle.
  - Each cycle that holds a base: sc_en=1, sc_data=next base, and the remaining count decrements.
  - Empty register: sc_en=0 and sc_data holds its last value (a bubble).
  - When the count reaches 0 after the last base, go to DRAIN. Unused bases in the final word are discarded and no further word is accepted.
- DRAIN:
  - sc_en=0 throughout.
  - sc_vld is ignored before DRAIN.
  - The first cycle with sc_vld=1 captures sc_result into res_score (res_timeout=0) and goes to REPORT.
- REPORT:
  - res_valid=1 and the result is held stable until res_ready, then return to IDLE.
- cmd_ready=0 and tgt_ready=0 outside IDLE/STREAM respectively.

## Timing
- Command accepted in cycle T.
  - CLEAR runs in cycles T+1 and T+2.
  - The first base appears on sc_data/sc_en in cycle T+3 at the earliest.
- With tgt_valid held high, the job occupies N consecutive sc_en cycles for tlen=N, with no bubbles.
- sc_query and sc_output_select update at T+1 and stay stable until the next acceptance.
- Result latency is 1 cycle from sc_vld sampled in DRAIN to res_valid.
- Reset values while rst=1:
  - state=IDLE.
  - sc_rst_n=0, sc_en=0, sc_data=0.
  - sc_query=0, sc_output_select=0.
  - cmd_ready=0, tgt_ready=0.
  - res_valid=0, res_score=ZERO, res_timeout=0.
- cmd_ready rises on the first cycle after rst deasserts.
- rst mid-job aborts immediately to the reset values. A partially consumed target word is dropped, and no result is produced.
- A cmd_valid presented in REPORT is not accepted until the cycle after the res handshake.

## Configuration
- SW_DRIVER_TIMEOUT_EN defined:
  - A DRAIN cycle counter is present.
  - After TIMEOUT cycles with no sc_vld, go to REPORT with res_score=ZERO and res_timeout=1.
- Undefined:
  - No counter is present; DRAIN waits indefinitely.
  - res_timeout is tied to 0.

## Structure
- Shared package sw_pkg holds:
  - the state enum;
  - nucleotide constants _A=2'b10, _G=2'b11, _T=2'b00, _C=2'b01;
  - the ZERO function of SCORE_WIDTH;
  - log2b.
- One sub-module: sw_base_serializer, covering the word shift register, tgt handshake and remaining-base count. It outputs base/valid/last to the FSM.

## Test plan
- qlen=4, tlen=20, WORD_BASES=16, tgt_valid held high:
  - 2 words are accepted.
  - Exactly 20 consecutive sc_en cycles, starting at T+3.
  - The last 12 bases of word 2 are discarded.
- tgt_valid low for 3 cycles mid-word boundary: exactly 3 sc_en=0 bubbles, and base order is preserved.
- Stub array asserts sc_vld with sc_result=0x80A at DRAIN cycle 5: res_score=0x80A and res_timeout=0 at the next cycle, held until res_ready.
- tlen=0 or qlen=0: no sc_en pulses, and res_score=0x800 with res_timeout=0 after CLEAR.
- SW_DRIVER_TIMEOUT_EN defined and sc_vld never asserted: res_timeout=1 and res_score=0x800 after 136 DRAIN cycles.
- rst asserted during STREAM: next cycle shows sc_en=0, sc_rst_n=0 and res_valid=0; a new job then runs cleanly.
